// File: rtl/irq_arb_pkg.sv
// Shared definitions for the external interrupt arbiter: register offsets,
// FSM encodings and field widths.
package irq_arb_pkg;

    localparam int PRIO_W  = 3;
    localparam int ID_NONE = 0;

    localparam logic [4:0] ADDR_PENDING   = 5'h00;
    localparam logic [4:0] ADDR_ENABLE    = 5'h04;
    localparam logic [4:0] ADDR_THRESHOLD = 5'h08;
    localparam logic [4:0] ADDR_CLAIM     = 5'h0C;
    localparam logic [4:0] ADDR_PRIO0     = 5'h10;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ASSERT     = 2'd1,
        WAIT_CLAIM = 2'd2,
        SERVICE    = 2'd3
    } state_t;

    // Byte offsets are word aligned; the low two address bits never select anything.
    function automatic logic [4:0] word_addr(input logic [4:0] a);
        return {a[4:2], 2'b00};
    endfunction

endpackage

// File: rtl/irq_arbiter_if.sv
// Register-bus interface of the interrupt arbiter: byte address, write data,
// one-cycle strobes and combinational read data.
interface irq_arbiter_if;
    logic [4:0]  a;
    logic [31:0] d;
    logic        we;
    logic        rd;
    logic [31:0] spo;

    modport master (output a, output d, output we, output rd, input spo);
    modport slave  (input a, input d, input we, input rd, output spo);
endinterface

// File: rtl/irq_arb_select.sv
// Combinational winner selection: highest priority among eligible sources,
// ties resolved toward the lowest ID; ID 0 when nothing is eligible.
module irq_arb_select
    import irq_arb_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int ID_W  = 4
) (
    input  logic [N_SRC-1:0]             i_elig,
    input  logic [N_SRC-1:0][PRIO_W-1:0] i_prio,
    output logic [ID_W-1:0]              o_best_id
);
    logic [PRIO_W-1:0] w_best_prio;

    // Ascending scan with a strict compare keeps the lower ID on equal priority.
    always_comb begin
        o_best_id   = ID_W'(ID_NONE);
        w_best_prio = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (i_elig[i] && ((o_best_id == ID_W'(ID_NONE)) || (i_prio[i] > w_best_prio))) begin
                o_best_id   = ID_W'(i + 1);
                w_best_prio = i_prio[i];
            end
        end
    end

endmodule

// File: rtl/irq_arbiter.sv
// Memory-mapped external interrupt arbiter driving m_eip with claim/complete.
// Define IRQ_ARB_PRIORITY_EN to build the THRESHOLD and PRIORITY registers.
module irq_arbiter
    import irq_arb_pkg::*;
#(
    parameter int N_SRC = 8,
    parameter int ID_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] irq,
    irq_arbiter_if.slave     bus,
    output logic             m_eip,
    input  logic             m_eip_reply
);
    state_t                       r_state, w_next;
    logic [N_SRC-1:0]             r_irq_prev, r_pending, r_enable;
    logic [N_SRC-1:0]             w_rise, w_elig, w_clr;
    logic [N_SRC-1:0][PRIO_W-1:0] w_prio;
    logic [ID_W-1:0]              w_best_id, r_claimed_id;
    logic [4:0]                   w_word;
    logic [31:0]                  w_spo;
    logic                         r_m_eip, w_claim_rd, w_claim_fire, w_complete, w_unused;

    assign w_word       = word_addr(bus.a);
    assign w_rise       = irq & ~r_irq_prev;
    assign w_claim_rd   = bus.rd && (w_word == ADDR_CLAIM);
    assign w_claim_fire = w_claim_rd && (r_state != SERVICE);
    assign w_complete   = bus.we && (w_word == ADDR_CLAIM) && (r_state == SERVICE)
                          && (bus.d[ID_W-1:0] == r_claimed_id);
    assign w_unused     = ^{bus.a[1:0], bus.d};

`ifdef IRQ_ARB_PRIORITY_EN
    logic [PRIO_W-1:0]            r_threshold;
    logic [N_SRC-1:0][PRIO_W-1:0] r_prio;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_threshold <= '0;
            r_prio      <= '0;
        end else if (bus.we) begin
            if (w_word == ADDR_THRESHOLD)
                r_threshold <= bus.d[PRIO_W-1:0];
            for (int i = 0; i < N_SRC; i++)
                if (bus.a[4] && ((i / 8) == int'(bus.a[3:2])))
                    r_prio[i] <= bus.d[4*(i%8) +: PRIO_W];
        end
    end

    always_comb begin
        w_prio = r_prio;
        w_elig = '0;
        for (int i = 0; i < N_SRC; i++)
            w_elig[i] = r_pending[i] && r_enable[i] && (r_prio[i] > r_threshold);
    end
`else
    // Equal priorities reduce the selector to a lowest-ID pick.
    always_comb begin
        w_elig = r_pending & r_enable;
        w_prio = '0;
        for (int i = 0; i < N_SRC; i++)
            w_prio[i] = PRIO_W'(1);
    end
`endif

    irq_arb_select #(.N_SRC(N_SRC), .ID_W(ID_W)) u_select (
        .i_elig    (w_elig),
        .i_prio    (w_prio),
        .o_best_id (w_best_id)
    );

    always_comb begin
        w_clr = '0;
        for (int i = 0; i < N_SRC; i++)
            w_clr[i] = w_claim_fire && (w_best_id == ID_W'(i + 1));
    end

    always_comb begin
        w_spo = '0;
        case (w_word)
            ADDR_PENDING: w_spo[N_SRC-1:0] = r_pending;
            ADDR_ENABLE:  w_spo[N_SRC-1:0] = r_enable;
            ADDR_CLAIM:   if (r_state != SERVICE) w_spo[ID_W-1:0] = w_best_id;
`ifdef IRQ_ARB_PRIORITY_EN
            ADDR_THRESHOLD: w_spo[PRIO_W-1:0] = r_threshold;
            default: begin
                for (int i = 0; i < N_SRC; i++)
                    if (bus.a[4] && ((i / 8) == int'(bus.a[3:2])))
                        w_spo[4*(i%8) +: PRIO_W] = r_prio[i];
            end
`else
            default: ;
`endif
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       if (w_best_id != ID_W'(ID_NONE)) w_next = ASSERT;
            ASSERT: begin
                if (m_eip_reply)                         w_next = WAIT_CLAIM;
                else if (w_best_id == ID_W'(ID_NONE))    w_next = IDLE;
            end
            WAIT_CLAIM: if (w_claim_rd)
                            w_next = (w_best_id != ID_W'(ID_NONE)) ? SERVICE : IDLE;
            SERVICE:    if (w_complete) w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end

    // m_eip only follows a stay in ASSERT, so it is never high in WAIT_CLAIM/SERVICE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_m_eip      <= 1'b0;
            r_irq_prev   <= '0;
            r_pending    <= '0;
            r_enable     <= '0;
            r_claimed_id <= '0;
        end else begin
            r_state    <= w_next;
            r_m_eip    <= (r_state == ASSERT) && (w_next == ASSERT);
            r_irq_prev <= irq;
            r_pending  <= (r_pending & ~w_clr) | w_rise;
            if (bus.we && (w_word == ADDR_ENABLE))
                r_enable <= bus.d[N_SRC-1:0];
            if ((r_state == WAIT_CLAIM) && w_claim_rd)
                r_claimed_id <= w_best_id;
            else if (w_complete)
                r_claimed_id <= '0;
        end
    end

    assign m_eip   = r_m_eip;
    assign bus.spo = w_spo;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter covering both IRQ_ARB_PRIORITY_EN builds.
module tb_irq_arbiter;
    import irq_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq;
    logic       m_eip;
    logic       m_eip_reply;
    int         vectors = 0;
    int         miscompares = 0;

    irq_arbiter_if bus_if ();

    irq_arbiter #(.N_SRC(8), .ID_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .irq         (irq),
        .bus         (bus_if),
        .m_eip       (m_eip),
        .m_eip_reply (m_eip_reply)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data);
        bus_if.a  = addr;
        bus_if.d  = data;
        bus_if.we = 1'b1;
        cyc(1);
        bus_if.we = 1'b0;
    endtask

    task automatic rdchk(input logic [4:0] addr, input logic [31:0] exp, input string tag);
        bus_if.a = addr;
        #1;
        check(tag, bus_if.spo, exp);
    endtask

    task automatic claim(input logic [31:0] exp, input string tag);
        bus_if.a  = ADDR_CLAIM;
        bus_if.rd = 1'b1;
        #1;
        check(tag, bus_if.spo, exp);
        cyc(1);
        bus_if.rd = 1'b0;
    endtask

    task automatic reply();
        m_eip_reply = 1'b1;
        cyc(1);
        m_eip_reply = 1'b0;
    endtask

    task automatic wait_eip(input string tag);
        int n = 0;
        while (m_eip !== 1'b1 && n < 12) begin
            cyc(1);
            n++;
        end
        check(tag, {31'd0, m_eip}, 32'd1);
    endtask

    task automatic round(input logic [31:0] id, input string tag);
        wait_eip({tag, "_eip"});
        reply();
        check({tag, "_drop"}, {31'd0, m_eip}, 32'd0);
        claim(id, {tag, "_claim"});
        wr(ADDR_CLAIM, id);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; irq = '0; m_eip_reply = 1'b0;
        bus_if.a = '0; bus_if.d = '0; bus_if.we = 1'b0; bus_if.rd = 1'b0;
        cyc(2);
        check("rst_m_eip", {31'd0, m_eip}, 32'd0);
        rdchk(ADDR_PENDING, 32'h0, "rst_pending");
        rdchk(ADDR_ENABLE, 32'h0, "rst_enable");
        rst_n = 1'b1;
        cyc(1);

        // Basic flow on source 0 with minimum latency
        wr(ADDR_ENABLE, 32'hFFFF_FF01);
        rdchk(ADDR_ENABLE, 32'h01, "enable_rb");
`ifdef IRQ_ARB_PRIORITY_EN
        wr(ADDR_PRIO0, 32'h1);
`endif
        irq = 8'h01;
        cyc(1);
        rdchk(ADDR_PENDING, 32'h01, "pend_set");
        check("lat1", {31'd0, m_eip}, 32'd0);
        irq = 8'h00;
        cyc(1);
        check("lat2", {31'd0, m_eip}, 32'd0);
        cyc(1);
        check("lat3", {31'd0, m_eip}, 32'd1);
        reply();
        check("reply_drop", {31'd0, m_eip}, 32'd0);
        claim(32'h1, "claim1");
        rdchk(ADDR_PENDING, 32'h0, "pend_after_claim");
        claim(32'h0, "claim_in_service");

        // New edge during service; bad then good complete
        irq = 8'h01;
        cyc(1);
        irq = 8'h00;
        cyc(3);
        check("svc_no_eip", {31'd0, m_eip}, 32'd0);
        rdchk(ADDR_PENDING, 32'h01, "svc_pend");
        wr(ADDR_CLAIM, 32'h2);
        cyc(2);
        check("bad_complete", {31'd0, m_eip}, 32'd0);
        wr(ADDR_CLAIM, 32'h1);
        cyc(1);
        check("complete_lat", {31'd0, m_eip}, 32'd0);
        cyc(1);
        check("complete_reassert", {31'd0, m_eip}, 32'd1);

        // Masking while asserted
        wr(ADDR_ENABLE, 32'h0);
        cyc(1);
        check("mask_drop", {31'd0, m_eip}, 32'd0);
        rdchk(ADDR_PENDING, 32'h01, "mask_keep_pend");
        wr(ADDR_ENABLE, 32'h1);
        cyc(1);
        check("reen_lat", {31'd0, m_eip}, 32'd0);
        cyc(1);
        check("reen_eip", {31'd0, m_eip}, 32'd1);

        // Claim straight from ASSERT
        claim(32'h1, "claim_in_assert");
        cyc(1);
        check("assert_claim_drop", {31'd0, m_eip}, 32'd0);
        rdchk(ADDR_PENDING, 32'h0, "assert_claim_pend");

`ifdef IRQ_ARB_PRIORITY_EN
        wr(ADDR_ENABLE, 32'hFF);
        wr(ADDR_PRIO0, 32'h0750_0500);
        rdchk(ADDR_PRIO0, 32'h0750_0500, "prio_rb");
        rdchk(5'h14, 32'h0, "prio1_rb");
        irq = 8'h64;
        cyc(1);
        irq = 8'h00;
        rdchk(ADDR_PENDING, 32'h64, "multi_pend");
        round(32'h7, "r7");
        round(32'h3, "r3");
        round(32'h6, "r6");

        wr(ADDR_THRESHOLD, 32'h4);
        rdchk(ADDR_THRESHOLD, 32'h4, "thr_rb");
        wr(ADDR_PRIO0, 32'h40);
        wr(ADDR_ENABLE, 32'h02);
        irq = 8'h02;
        cyc(1);
        irq = 8'h00;
        cyc(4);
        check("thr_block", {31'd0, m_eip}, 32'd0);
        wr(ADDR_THRESHOLD, 32'h3);
        cyc(2);
        check("thr_pass", {31'd0, m_eip}, 32'd1);
        reply();
        claim(32'h2, "thr_claim");
        wr(ADDR_CLAIM, 32'h2);
        wr(ADDR_THRESHOLD, 32'h0);

        wr(ADDR_ENABLE, 32'h01);
        irq = 8'h01;
        cyc(1);
        irq = 8'h00;
        cyc(4);
        check("prio0_masked", {31'd0, m_eip}, 32'd0);
        rdchk(ADDR_PENDING, 32'h01, "prio0_pend");
`else
        wr(ADDR_THRESHOLD, 32'h7);
        rdchk(ADDR_THRESHOLD, 32'h0, "thr_absent");
        wr(ADDR_PRIO0, 32'hFFFF_FFFF);
        rdchk(ADDR_PRIO0, 32'h0, "prio_absent");
        wr(ADDR_ENABLE, 32'hFF);
        irq = 8'h0A;
        cyc(1);
        irq = 8'h00;
        rdchk(ADDR_PENDING, 32'h0A, "two_pend");
        round(32'h2, "lowid2");
        round(32'h4, "lowid4");
        rdchk(ADDR_PENDING, 32'h0, "lowid_pend");
`endif

        // Reset in SERVICE with a line held high through release
        wr(ADDR_ENABLE, 32'h10);
`ifdef IRQ_ARB_PRIORITY_EN
        wr(ADDR_PRIO0, 32'h0001_0000);
`endif
        irq = 8'h10;
        wait_eip("pre_rst_eip");
        reply();
        claim(32'h5, "pre_rst_claim");
        rst_n = 1'b0;
        cyc(1);
        check("rst2_m_eip", {31'd0, m_eip}, 32'd0);
        rdchk(ADDR_PENDING, 32'h0, "rst2_pending");
        rdchk(ADDR_ENABLE, 32'h0, "rst2_enable");
        rst_n = 1'b1;
        cyc(1);
        rdchk(ADDR_PENDING, 32'h10, "held_edge");
        wr(ADDR_ENABLE, 32'h10);
`ifdef IRQ_ARB_PRIORITY_EN
        wr(ADDR_PRIO0, 32'h0001_0000);
`endif
        wait_eip("post_rst_eip");
        claim(32'h5, "post_rst_claim");
        irq = 8'h00;
        cyc(2);
        check("post_rst_drop", {31'd0, m_eip}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
